crash_course_io_debouncer: RTL

Input conditioning stage that sits directly upstream of the CPU I/O register block and drives its io_in bus. It synchronises each raw external input bit into the clk domain and debounces it with a per-bit stability counter. It presents a clean byte to the I/O block, plus single-cycle rise/fall pulses and a change flag for future interrupt/edge logic.

---
 rtl/crash_course_io_debouncer.sv | 100 ++++++++++
 1 files changed

// File: rtl/crash_course_io_debouncer.sv
// rtl/crash_course_io_debouncer.sv - per-bit synchroniser and stability-count debouncer feeding the I/O block's io_in
module crash_course_io_debouncer #(
    parameter int WIDTH          = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE_COUNT = 4
) (
    input  logic             clk,
    input  logic             async_rst,
    input  logic             clk_en,
    input  logic             system_enabled,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] io_in,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             changed
);

    localparam int CNT_WIDTH = $clog2(DEBOUNCE_COUNT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_COUNT - 1);

    logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]     sync_bit;
    logic [CNT_WIDTH-1:0] cnt_q    [WIDTH];
    logic [CNT_WIDTH-1:0] cnt_next [WIDTH];
    logic [WIDTH-1:0]     io_q;
    logic [WIDTH-1:0]     io_next;
    logic [WIDTH-1:0]     rise_q;
    logic [WIDTH-1:0]     rise_next;
    logic [WIDTH-1:0]     fall_q;
    logic [WIDTH-1:0]     fall_next;
    logic                 changed_q;
    logic                 tick;

    assign tick     = clk_en && system_enabled;
    assign sync_bit = sync_q[SYNC_STAGES-1];

    // The synchroniser runs every edge so metastability settling never depends on the enables.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= raw_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_comb begin
        io_next   = io_q;
        rise_next = '0;
        fall_next = '0;
        for (int b = 0; b < WIDTH; b++) begin
            cnt_next[b] = cnt_q[b];
        end
        if (tick) begin
            for (int b = 0; b < WIDTH; b++) begin
                if (sync_bit[b] == io_q[b]) begin
                    cnt_next[b] = '0;
                end else if (cnt_q[b] == CNT_MAX) begin
                    io_next[b]   = sync_bit[b];
                    cnt_next[b]  = '0;
                    rise_next[b] = sync_bit[b];
                    fall_next[b] = ~sync_bit[b];
                end else begin
                    cnt_next[b] = cnt_q[b] + 1'b1;
                end
            end
        end
    end

    // Pulses load from the combinational accept terms each edge, so they self-clear after one clk.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            io_q      <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
            for (int b = 0; b < WIDTH; b++) begin
                cnt_q[b] <= '0;
            end
        end else begin
            io_q      <= io_next;
            rise_q    <= rise_next;
            fall_q    <= fall_next;
            changed_q <= |(rise_next | fall_next);
            for (int b = 0; b < WIDTH; b++) begin
                cnt_q[b] <= cnt_next[b];
            end
        end
    end

    assign io_in      = io_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign changed    = changed_q;

endmodule
